// File: rtl/bin_to_bcd_seq_if.sv
// Start/result bundle for the sequential binary-to-BCD converter.
// master drives start/bin, slave returns busy/done/bcd/overflow.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W      = 10,
  parameter int NUM_DIGITS = 3
);
  logic                    start;
  logic [BIN_W-1:0]        bin;
  logic                    busy;
  logic                    done;
  logic [NUM_DIGITS*4-1:0] bcd;
  logic                    overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary to packed BCD, one input bit per clock.
// Saturates to all nines when the value does not fit the digits.
module bin_to_bcd_seq #(
  parameter int BIN_W      = 10,
  parameter int NUM_DIGITS = 3
) (
  input logic             clk,
  input logic             rst_n,
  bin_to_bcd_seq_if.slave io
);
  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [BIN_W-1:0]   sreg_q;
  logic [BCD_W-1:0]   scr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_out_q;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scr_sh;
  logic [BIN_W-1:0]   sreg_sh;
  logic               ovf_d;
  logic [BCD_W-1:0]   sat;
  logic               last;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (io.start) state_d = S_SHIFT;
      S_SHIFT: if (last)     state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-digit add-3 then one-bit left shift of {scratch, shiftreg}
  always_comb begin
    adj  = '0;
    sat  = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      adj[4*d +: 4] = (scr_q[4*d +: 4] >= 4'd5) ?
                      4'(scr_q[4*d +: 4] + 4'd3) :
                      scr_q[4*d +: 4];
      sat[4*d +: 4] = 4'h9;
    end
    scr_sh  = {adj[BCD_W-2:0], sreg_q[BIN_W-1]};
    sreg_sh = sreg_q << 1;
    ovf_d   = ovf_q | adj[BCD_W-1];
    last    = (cnt_q == CNT_W'(1));
  end

  // Datapath: capture on accept, shift while busy, publish on last bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_q    <= '0;
      scr_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (io.start) begin
            sreg_q <= io.bin;
            scr_q  <= '0;
            cnt_q  <= CNT_W'(BIN_W);
            ovf_q  <= 1'b0;
          end
        end
        S_SHIFT: begin
          sreg_q <= sreg_sh;
          scr_q  <= scr_sh;
          cnt_q  <= cnt_q - CNT_W'(1);
          ovf_q  <= ovf_d;
          if (last) begin
            bcd_q     <= ovf_d ? sat : scr_sh;
            ovf_out_q <= ovf_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.busy     = (state_q != S_IDLE);
  assign io.done     = (state_q == S_DONE);
  assign io.bcd      = bcd_q;
  assign io.overflow = ovf_out_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and exhaustive bench for bin_to_bcd_seq.
// Scoreboard queue filled at accept, drained when a result is due.
module tb_bin_to_bcd_seq;
  localparam int BW = 10;
  localparam int ND = 3;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bin_to_bcd_seq_if #(.BIN_W(BW), .NUM_DIGITS(ND)) io ();
  bin_to_bcd_seq_if #(.BIN_W(4), .NUM_DIGITS(1)) sio ();

  bin_to_bcd_seq #(.BIN_W(BW), .NUM_DIGITS(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  bin_to_bcd_seq #(.BIN_W(4), .NUM_DIGITS(1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (sio.slave)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errs    = 0;
  int          rem     = 0;
  exp_t        sb[$];
  logic [11:0] hold_bcd = '0;
  logic        hold_ovf = 1'b0;

  function automatic exp_t ref_conv(input int v);
    exp_t e;
    if (v > 999) begin
      e.bcd = 12'h999;
      e.ovf = 1'b1;
    end else begin
      e.bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic [BW-1:0] b);
    exp_t e;
    io.start = s;
    io.bin   = b;
    if (rem == 0 && s) begin
      sb.push_back(ref_conv(int'(b)));
      rem = BW + 1;
    end else if (rem > 0) begin
      rem--;
    end
    @(negedge clk);
    chk("busy", {31'd0, io.busy}, {31'd0, rem != 0});
    chk("done", {31'd0, io.done}, {31'd0, rem == 1});
    if (rem == 1 && sb.size() > 0) begin
      e = sb.pop_front();
      hold_bcd = e.bcd;
      hold_ovf = e.ovf;
    end
    chk("bcd", {20'd0, io.bcd}, {20'd0, hold_bcd});
    chk("overflow", {31'd0, io.overflow}, {31'd0, hold_ovf});
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    io.start = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    rem      = 0;
    hold_bcd = '0;
    hold_ovf = 1'b0;
    sb.delete();
    chk("rst_busy", {31'd0, io.busy}, 32'd0);
    chk("rst_done", {31'd0, io.done}, 32'd0);
    chk("rst_bcd", {20'd0, io.bcd}, 32'd0);
    chk("rst_ovf", {31'd0, io.overflow}, 32'd0);
  endtask

  task automatic run_small(input logic [3:0] v,
                           input logic [3:0] eb,
                           input logic eo);
    int n;
    sio.start = 1'b1;
    sio.bin   = v;
    @(negedge clk);
    sio.start = 1'b0;
    n = 0;
    while (!sio.done && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("small_done", {31'd0, sio.done}, 32'd1);
    chk("small_lat", n, 32'd4);
    chk("small_bcd", {28'd0, sio.bcd}, {28'd0, eb});
    chk("small_ovf", {31'd0, sio.overflow}, {31'd0, eo});
    @(negedge clk);
  endtask

  initial begin
    io.start  = 1'b0;
    io.bin    = '0;
    sio.start = 1'b0;
    sio.bin   = '0;
    @(negedge clk);
    do_reset();

    step(1'b1, 10'd0);
    repeat (BW + 1) step(1'b0, 10'd0);

    step(1'b1, 10'd255);
    repeat (BW + 1) step(1'b0, 10'd0);
    step(1'b1, 10'd999);
    repeat (BW + 1) step(1'b0, 10'd0);
    step(1'b1, 10'd7);
    repeat (BW + 1) step(1'b0, 10'd0);

    step(1'b1, 10'd1000);
    repeat (BW + 1) step(1'b0, 10'd0);
    step(1'b1, 10'd1023);
    repeat (BW + 1) step(1'b0, 10'd0);
    step(1'b1, 10'd42);
    repeat (BW + 1) step(1'b0, 10'd0);

    for (int i = 0; i < 30; i++)
      step(1'b1, 10'(100 + i * 37));
    repeat (BW + 2) step(1'b0, 10'd0);
    chk("sb_empty", sb.size(), 32'd0);

    step(1'b1, 10'd512);
    repeat (4) step(1'b0, 10'd0);
    do_reset();
    repeat (20) step(1'b0, 10'd0);
    step(1'b1, 10'd512);
    repeat (BW + 1) step(1'b0, 10'd0);

    for (int v = 0; v < 1024; v++) begin
      step(1'b1, 10'(v));
      repeat (BW + 1) step(1'b0, 10'd0);
    end
    chk("sb_final", sb.size(), 32'd0);

    run_small(4'd9, 4'h9, 1'b0);
    run_small(4'd15, 4'h9, 1'b1);
    run_small(4'd3, 4'h3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
